// File: rtl/mem_bus_if.sv
// mem_bus_if: data-side bus master behind the mem stage.
// Converts the single-cycle mem RAM request into a req/ack bus transaction.
// Sub-word stores use read-modify-write: the word is read and returned to mem
// for byte merging, then the merged word is written back.
// The pipeline is stalled until the transaction completes.
// Optional feature: define BUS_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES cycles without ack. An abort pulses bus_err_out for one cycle.
module mem_bus_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  ram_ce_in,
    input  logic                  ram_write_request_in,
    input  logic                  word_store_in,
    input  logic [ADDR_WIDTH-1:0] ram_addr_in,
    input  logic [DATA_WIDTH-1:0] ram_wdata_in,
    output logic [DATA_WIDTH-1:0] ram_rdata_out,
    output logic                  stall_out,
    output logic                  bus_req_out,
    output logic                  bus_we_out,
    output logic [ADDR_WIDTH-1:0] bus_addr_out,
    output logic [DATA_WIDTH-1:0] bus_wdata_out,
    input  logic [DATA_WIDTH-1:0] bus_rdata_in,
    input  logic                  bus_ack_in,
    output logic                  bus_err_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // The byte offset is resolved inside mem; the bus only sees word addresses.
    logic unused_byte_offset;
    assign unused_byte_offset = ^ram_addr_in[1:0];

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    // The last counted ack-less cycle aborts the transaction.
    assign timeout = !bus_ack_in && (cnt_q == CNT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        // NOTE: every signal is given a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        write_d = write_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ram_ce_in) begin
                    addr_d  = {ram_addr_in[ADDR_WIDTH-1:2], 2'b00};
                    write_d = ram_write_request_in;
                    req_d   = 1'b1;
`ifdef BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (ram_write_request_in && word_store_in) begin
                        state_d = ST_WR;
                        we_d    = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        we_d    = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (bus_ack_in) begin
                    rdata_d = bus_rdata_in;
                    if (write_q) begin
                        state_d = ST_WR;
                        we_d    = 1'b1;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else if (timeout) begin
                    // A timed-out store skips the write phase.
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_WR: begin
                if (bus_ack_in) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
`ifdef BUS_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; an asynchronous reset drops the bus cycle immediately.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, whatever the statement order.
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus_req_out   = req_q;
    assign bus_we_out    = we_q;
    assign bus_addr_out  = addr_q;
    assign ram_rdata_out = rdata_q;

    // The upstream pipeline is frozen during WR, so mem's merged data is stable.
    assign bus_wdata_out = (state_q == ST_WR) ? ram_wdata_in : '0;

    // Stall drops in DONE, so the pipeline advances at the end of that cycle.
    assign stall_out = ((state_q == ST_IDLE) && ram_ce_in) || (state_q == ST_RD) || (state_q == ST_WR);

`ifdef BUS_TIMEOUT_EN
    assign bus_err_out = err_q;
`else
    assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed testbench for mem_bus_if.
// The bench acts as a simple slave that inserts a chosen number of wait cycles.
// Defining BUS_TIMEOUT_EN also runs the timeout abort case, with TIMEOUT_CYCLES set to 4.
module tb_mem_bus_if;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        ram_ce_in = 1'b0;
    logic        ram_write_request_in = 1'b0;
    logic        word_store_in = 1'b0;
    logic [31:0] ram_addr_in = '0;
    logic [31:0] ram_wdata_in = '0;
    logic [31:0] ram_rdata_out;
    logic        stall_out;
    logic        bus_req_out;
    logic        bus_we_out;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [31:0] bus_rdata_in = '0;
    logic        bus_ack_in = 1'b0;
    logic        bus_err_out;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_if #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .ram_ce_in(ram_ce_in),
        .ram_write_request_in(ram_write_request_in),
        .word_store_in(word_store_in),
        .ram_addr_in(ram_addr_in),
        .ram_wdata_in(ram_wdata_in),
        .ram_rdata_out(ram_rdata_out),
        .stall_out(stall_out),
        .bus_req_out(bus_req_out),
        .bus_we_out(bus_we_out),
        .bus_addr_out(bus_addr_out),
        .bus_wdata_out(bus_wdata_out),
        .bus_rdata_in(bus_rdata_in),
        .bus_ack_in(bus_ack_in),
        .bus_err_out(bus_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one mem request and plays the slave until the DONE cycle.
    // The DONE cycle is the first cycle after issue in which stall_out is low.
    task automatic run_txn(
        input  logic [31:0] addr,
        input  logic        wr,
        input  logic        ws,
        input  logic [31:0] wdata,
        input  logic [31:0] rword,
        input  int          rd_waits,
        input  int          wr_waits,
        output int          stalls,
        output int          acks,
        output int          rd_cyc,
        output int          wr_cyc,
        output logic [31:0] done_rdata,
        output logic        done_req,
        output logic        done_err
    );
        logic [31:0] exp_addr;
        int          rw;
        int          ww;
        bit          done;
        exp_addr   = {addr[31:2], 2'b00};
        stalls     = 0;
        acks       = 0;
        rd_cyc     = 0;
        wr_cyc     = 0;
        rw         = 0;
        ww         = 0;
        done       = 1'b0;
        done_rdata = '0;
        done_req   = 1'b1;
        done_err   = 1'b0;
        @(negedge clk_in);
        ram_ce_in            = 1'b1;
        ram_write_request_in = wr;
        word_store_in        = ws;
        ram_addr_in          = addr;
        ram_wdata_in         = wdata;
        bus_ack_in           = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (stall_out) stalls++;
            bus_ack_in   = 1'b0;
            bus_rdata_in = 32'hDEAD_BEEF;
            if (c > 0 && !stall_out) begin
                done       = 1'b1;
                done_rdata = ram_rdata_out;
                done_req   = bus_req_out;
                done_err   = bus_err_out;
                ram_ce_in  = 1'b0;
            end else if (bus_req_out) begin
                check("bus_addr", bus_addr_out, exp_addr);
                if (!bus_we_out) begin
                    rd_cyc++;
                    if (rw == rd_waits) begin
                        bus_ack_in   = 1'b1;
                        bus_rdata_in = rword;
                        acks++;
                    end else begin
                        rw++;
                    end
                end else begin
                    wr_cyc++;
                    check("bus_wdata", bus_wdata_out, wdata);
                    if (ww == wr_waits) begin
                        bus_ack_in = 1'b1;
                        acks++;
                    end else begin
                        ww++;
                    end
                end
            end
            if (!done) @(negedge clk_in);
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL txn_done: no DONE cycle within 64 cycles for addr 0x%08h", addr);
            ram_ce_in  = 1'b0;
            bus_ack_in = 1'b0;
        end
    endtask

    int          st, ak, rc, wc;
    logic [31:0] rd;
    logic        rq, er;

    initial begin
        // Reset state: async reset holds everything at zero.
        #1;
        check("rst_req", bus_req_out, 0);
        check("rst_we", bus_we_out, 0);
        check("rst_addr", bus_addr_out, 0);
        check("rst_wdata", bus_wdata_out, 0);
        check("rst_rdata", ram_rdata_out, 0);
        check("rst_stall", stall_out, 0);
        check("rst_err", bus_err_out, 0);
        repeat (3) @(negedge clk_in);
        reset_n_in = 1'b1;

        // Idle with ce low: a stray ack causes no activity.
        @(negedge clk_in);
        bus_ack_in   = 1'b1;
        bus_rdata_in = 32'hFFFF_FFFF;
        #1;
        check("idle_stall", stall_out, 0);
        check("idle_req", bus_req_out, 0);
        @(negedge clk_in);
        bus_ack_in = 1'b0;
        #1;
        check("idle_req_after_ack", bus_req_out, 0);
        check("idle_rdata_after_ack", ram_rdata_out, 0);

        // Load, zero wait.
        run_txn(32'h0000_1006, 1'b0, 1'b0, 32'h0, 32'hA1B2_C3D4, 0, 0, st, ak, rc, wc, rd, rq, er);
        check("ld_stalls", st, 2);
        check("ld_acks", ak, 1);
        check("ld_rd_cycles", rc, 1);
        check("ld_wr_cycles", wc, 0);
        check("ld_rdata_done", rd, 32'hA1B2_C3D4);
        check("ld_req_done", rq, 0);
        check("ld_err_done", er, 0);

        // Byte store: read-modify-write.
        run_txn(32'h0000_2001, 1'b1, 1'b0, 32'h1122_AA44, 32'h1122_3344, 0, 0, st, ak, rc, wc, rd, rq, er);
        check("sb_stalls", st, 3);
        check("sb_acks", ak, 2);
        check("sb_rd_cycles", rc, 1);
        check("sb_wr_cycles", wc, 1);
        check("sb_rdata_done", rd, 32'h1122_3344);
        check("sb_req_done", rq, 0);

        // Word store: no read phase; the read word from the byte store is kept.
        run_txn(32'h0000_3000, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 0, st, ak, rc, wc, rd, rq, er);
        check("sw_stalls", st, 2);
        check("sw_acks", ak, 1);
        check("sw_rd_cycles", rc, 0);
        check("sw_wr_cycles", wc, 1);
        check("sw_rdata_held", rd, 32'h1122_3344);

        // Halfword store with 3 read waits and 2 write waits.
        run_txn(32'h0000_5002, 1'b1, 1'b0, 32'hBEEF_7766, 32'h9988_7766, 3, 2, st, ak, rc, wc, rd, rq, er);
        check("sh_stalls", st, 8);
        check("sh_acks", ak, 2);
        check("sh_rd_cycles", rc, 4);
        check("sh_wr_cycles", wc, 3);
        check("sh_rdata_done", rd, 32'h9988_7766);
        check("sh_req_done", rq, 0);
        check("sh_err_done", er, 0);

`ifdef BUS_TIMEOUT_EN
        // Load without any ack: four ack-less RD cycles, then an abort.
        run_txn(32'h0000_6008, 1'b0, 1'b0, 32'h0, 32'h0, 1000, 0, st, ak, rc, wc, rd, rq, er);
        check("to_stalls", st, 5);
        check("to_acks", ak, 0);
        check("to_rd_cycles", rc, 4);
        check("to_err_done", er, 1);
        check("to_rdata_done", rd, 0);
        check("to_req_done", rq, 0);
        @(negedge clk_in);
        #1;
        check("to_err_pulse_end", bus_err_out, 0);
`endif

        // Reset asserted while the DUT is in WR.
        @(negedge clk_in);
        ram_ce_in            = 1'b1;
        ram_write_request_in = 1'b1;
        word_store_in        = 1'b1;
        ram_addr_in          = 32'h0000_4000;
        ram_wdata_in         = 32'h55AA_55AA;
        bus_ack_in           = 1'b0;
        @(negedge clk_in);
        ram_ce_in = 1'b0;
        #1;
        check("rstwr_in_wr_req", bus_req_out, 1);
        check("rstwr_in_wr_we", bus_we_out, 1);
        check("rstwr_in_wr_stall", stall_out, 1);
        #1;
        reset_n_in = 1'b0;
        #1;
        check("rstwr_req", bus_req_out, 0);
        check("rstwr_we", bus_we_out, 0);
        check("rstwr_stall", stall_out, 0);
        check("rstwr_wdata", bus_wdata_out, 0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            #1;
            check("post_rst_req", bus_req_out, 0);
            check("post_rst_stall", stall_out, 0);
        end

        // A load after reset recovery.
        run_txn(32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0BAD_F00D, 1, 0, st, ak, rc, wc, rd, rq, er);
        check("rec_stalls", st, 3);
        check("rec_acks", ak, 1);
        check("rec_rdata_done", rd, 32'h0BAD_F00D);

        @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
